// File: rtl/div_8bit_sign_pkg.sv
// Shared definitions for the signed 8-bit divider: FSM encoding, default width and
// a sign-magnitude helper that the signed multiplier also uses.
package div_8bit_sign_pkg;

  localparam int unsigned DivWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2
  } div_state_e;

  // One extra bit so that |-2^(W-1)| is exact.
  function automatic logic [DivWidth:0] to_mag(input logic [DivWidth-1:0] v);
    logic [DivWidth:0] ext;
    ext = {v[DivWidth-1], v};
    return v[DivWidth-1] ? -ext : ext;
  endfunction

endpackage

// File: rtl/div_8bit_sign_if.sv
// Request/response bundle for the signed divider: the master issues start/a/b, the slave
// returns busy/done and the registered results.
interface div_8bit_sign_if import div_8bit_sign_pkg::*; #(
  parameter int unsigned WIDTH = DivWidth
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             dbz;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, quot, rem, dbz, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, quot, rem, dbz, ovf
  );
endinterface

// File: rtl/div_restore_step.sv
// One combinational restoring-division iteration on unsigned magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep or restore.
module div_restore_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             unused_hi;

  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = {1'b0, shifted} - {2'b00, div_i};
    q_o     = ~diff[WIDTH+1];
    // The kept value is always below the divisor, so it fits in WIDTH bits.
    rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

  assign unused_hi = ^{diff[WIDTH], shifted[WIDTH]};
endmodule

// File: rtl/div_8bit_sign.sv
// Iterative signed restoring divider, one quotient bit per clock, sign-magnitude based.
// Define DIV_OVF_SAT_EN to saturate the -2^(W-1) / -1 quotient instead of wrapping it.
module div_8bit_sign import div_8bit_sign_pkg::*; #(
  parameter int unsigned WIDTH = DivWidth
) (
  input logic            clk,
  input logic            rst,
  div_8bit_sign_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);
  typedef logic [WIDTH-1:0] word_t;

  localparam word_t MinNeg = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef DIV_OVF_SAT_EN
  localparam word_t OvfQuot = ~MinNeg;
`else
  localparam word_t OvfQuot = MinNeg;
`endif

  div_state_e      state_q, state_d;
  word_t           a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  word_t           prem_q, prem_d, qmag_q, qmag_d;
  word_t           quot_q, quot_d, rem_q, rem_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d;
  logic            zero_div_q, zero_div_d, ovf_case_q, ovf_case_d;
  logic            busy_q, busy_d, done_q, done_d, dbz_q, dbz_d, ovf_q, ovf_d;
  word_t           step_rem;
  logic            step_q;

  div_restore_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (prem_q),
    .bit_i (a_mag_q[cnt_q]),
    .div_i (b_mag_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    state_d    = state_q;
    a_mag_d    = a_mag_q;
    b_mag_d    = b_mag_q;
    prem_d     = prem_q;
    qmag_d     = qmag_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    zero_div_d = zero_div_q;
    ovf_case_d = ovf_case_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          busy_d     = 1'b1;
          a_mag_d    = WIDTH'(to_mag(bus.a));
          b_mag_d    = WIDTH'(to_mag(bus.b));
          neg_quot_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          neg_rem_d  = bus.a[WIDTH-1];
          prem_d     = '0;
          qmag_d     = '0;
          cnt_d      = CntW'(WIDTH - 1);
          zero_div_d = (bus.b == '0);
          ovf_case_d = (bus.a == MinNeg) && (bus.b == '1);
          state_d    = (bus.b == '0) ? StFix : StCalc;
        end
      end
      StCalc: begin
        prem_d = step_rem;
        qmag_d = {qmag_q[WIDTH-2:0], step_q};
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = zero_div_q;
        ovf_d   = ovf_case_q;
        state_d = StIdle;
        if (zero_div_q) begin
          quot_d = '1;
          rem_d  = neg_rem_q ? -a_mag_q : a_mag_q;
        end else if (ovf_case_q) begin
          quot_d = OvfQuot;
          rem_d  = '0;
        end else begin
          quot_d = neg_quot_q ? -qmag_q : qmag_q;
          rem_d  = neg_rem_q ? -prem_q : prem_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      prem_q     <= '0;
      qmag_q     <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_div_q <= 1'b0;
      ovf_case_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_mag_q    <= a_mag_d;
      b_mag_q    <= b_mag_d;
      prem_q     <= prem_d;
      qmag_q     <= qmag_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      zero_div_q <= zero_div_d;
      ovf_case_q <= ovf_case_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.quot = quot_q;
  assign bus.rem  = rem_q;
  assign bus.dbz  = dbz_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_div_8bit_sign.sv
// Self-checking bench for div_8bit_sign: directed and random operands against an
// integer-arithmetic reference, plus handshake, busy-ignore and reset-abort scenarios.
module tb_div_8bit_sign;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  div_8bit_sign_if #(.WIDTH(8)) bus ();

  div_8bit_sign #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic dz, output logic ov);
    int ai;
    int bi;
    ai = $signed(a);
    bi = $signed(b);
    dz = 1'b0;
    ov = 1'b0;
    if (bi == 0) begin
      dz = 1'b1;
      q  = 8'hFF;
      r  = a;
    end else if (ai == -128 && bi == -1) begin
      ov = 1'b1;
      r  = 8'h00;
`ifdef DIV_OVF_SAT_EN
      q  = 8'h7F;
`else
      q  = 8'h80;
`endif
    end else begin
      q = 8'(ai / bi);
      r = 8'(ai % bi);
    end
  endfunction

  // Drives one request and collects what the DUT reports; lat=-1 means done never came.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int lat,
                       output logic [7:0] q, output logic [7:0] r, output logic dz,
                       output logic ov, output bit busy_ok, output bit pulse_ok);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    busy_ok = (bus.busy === 1'b1);
    lat     = -1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(posedge clk);
      else @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    q  = bus.quot;
    r  = bus.rem;
    dz = bus.dbz;
    ov = bus.ovf;
    if (bus.busy !== 1'b0) busy_ok = 1'b0;
    @(posedge clk);
    #1;
    pulse_ok = (bus.done === 1'b0) && (bus.quot === q) && (bus.rem === r);
  endtask

  task automatic test_reset();
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_tests++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_tests++;
    if (bus.quot !== 8'h00) begin n_fail++; $display("FAIL reset_quot got %h want 00", bus.quot); end
    n_tests++;
    if (bus.rem !== 8'h00) begin n_fail++; $display("FAIL reset_rem got %h want 00", bus.rem); end
    n_tests++;
    if ({bus.dbz, bus.ovf} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags got %b%b want 00", bus.dbz, bus.ovf);
    end
  endtask

  task automatic test_divide(input string tag, input logic [7:0] a, input logic [7:0] b);
    int lat, want_lat;
    logic [7:0] q, r, eq, er;
    logic dz, ov, edz, eov;
    bit busy_ok, pulse_ok;
    model(a, b, eq, er, edz, eov);
    want_lat = (b == 8'h00) ? 1 : 9;
    do_op(a, b, lat, q, r, dz, ov, busy_ok, pulse_ok);
    n_tests++;
    if (lat != want_lat) begin
      n_fail++;
      $display("FAIL %s_latency a=%0d b=%0d got %0d want %0d", tag, $signed(a), $signed(b),
               lat, want_lat);
    end
    n_tests++;
    if (q !== eq || r !== er) begin
      n_fail++;
      $display("FAIL %s_result a=%0d b=%0d got q=%0d r=%0d want q=%0d r=%0d", tag, $signed(a),
               $signed(b), $signed(q), $signed(r), $signed(eq), $signed(er));
    end
    n_tests++;
    if (dz !== edz || ov !== eov) begin
      n_fail++;
      $display("FAIL %s_flags a=%0d b=%0d got dbz=%b ovf=%b want dbz=%b ovf=%b", tag,
               $signed(a), $signed(b), dz, ov, edz, eov);
    end
    n_tests++;
    if (!busy_ok || !pulse_ok) begin
      n_fail++;
      $display("FAIL %s_handshake a=%0d b=%0d got busy_ok=%0d pulse_ok=%0d want 1 1", tag,
               $signed(a), $signed(b), busy_ok, pulse_ok);
    end
  endtask

  task automatic test_directed();
    logic [7:0] av [10] = '{8'd100, -8'sd100, 8'd100, -8'sd100, 8'd5, 8'h80, 8'd3, 8'h80,
                            8'd127, 8'h80};
    logic [7:0] bv [10] = '{8'd7, 8'd7, -8'sd7, -8'sd7, 8'd0, 8'hFF, 8'd10, 8'd1, 8'h80, 8'd0};
    for (int i = 0; i < 10; i++) test_divide("directed", av[i], bv[i]);
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      case ($urandom_range(0, 3))
        0: b = 8'($urandom_range(1, 4)) * (($urandom_range(0, 1) == 1) ? 8'hFF : 8'h01);
        1: b = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'h80;
        default: b = 8'($urandom);
      endcase
      test_divide("random", a, b);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    bit busy_ok;
    int extra_done;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd100;
    bus.b     = 8'd7;
    @(posedge clk);
    #1;
    busy_ok = (bus.busy === 1'b1);
    lat     = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus.start = (i == 3);
      bus.a     = (i == 3) ? 8'd50 : 8'($urandom);
      bus.b     = (i == 3) ? 8'd5 : 8'($urandom);
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    n_tests++;
    if (lat != 9 || bus.quot !== 8'd14 || bus.rem !== 8'd2) begin
      n_fail++;
      $display("FAIL busy_ignore_result got lat=%0d q=%0d r=%0d want lat=9 q=14 r=2", lat,
               $signed(bus.quot), $signed(bus.rem));
    end
    n_tests++;
    if (!busy_ok) begin n_fail++; $display("FAIL busy_ignore_busy got dropped want held"); end
    extra_done = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra_done++;
    end
    n_tests++;
    if (extra_done != 0) begin
      n_fail++;
      $display("FAIL busy_ignore_queued got %0d active cycles want 0", extra_done);
    end
  endtask

  task automatic test_reset_abort();
    int seen_done;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd100;
    bus.b     = 8'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.busy, bus.done, bus.dbz, bus.ovf} !== 4'b0000 || bus.quot !== 8'h00 ||
        bus.rem !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_clear got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b want all 0",
               bus.busy, bus.done, bus.quot, bus.rem, bus.dbz, bus.ovf);
    end
    seen_done = 0;
    repeat (2) begin @(posedge clk); #1; if (bus.done === 1'b1) seen_done++; end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (bus.done === 1'b1) seen_done++; end
    n_tests++;
    if (seen_done != 0) begin
      n_fail++;
      $display("FAIL abort_no_done got %0d done pulses want 0", seen_done);
    end
    test_divide("after_abort", 8'd9, 8'd3);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/div_8bit_sign.md
Name: div_8bit_sign

Overview:
- Iterative signed restoring divider. It is the inverse operation of the team's signed 8-bit multiplier and shares its sign-magnitude approach.
- It converts the operands to magnitudes, runs one quotient bit per clock, then re-applies signs.
- A start/busy/done handshake lets the block sit beside the multiplier in the arithmetic datapath.
- Results are registered and held until the next operation completes.

Parameters:
- WIDTH, 8, operand and result width in bits (two's complement).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  signed dividend.
- b  input  WIDTH  signed divisor.
- busy  output  1  high from the start-accept edge until done is raised.
- done  output  1  one-cycle pulse; results valid.
- quot  output  WIDTH  signed quotient.
- rem  output  WIDTH  signed remainder.
- dbz  output  1  divide-by-zero flag; valid with done, held.
- ovf  output  1  overflow flag (-2^(WIDTH-1) / -1); valid with done, held.

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, quot, rem, dbz, ovf and all internal registers go to 0.
- FSM states: IDLE, CALC, FIX.
- IDLE -> CALC, on an edge where start=1 and b!=0:
  - latch |a| and |b| (WIDTH+1-bit magnitude, so |-128|=128 is exact);
  - latch sign_q = a[MSB]^b[MSB] and sign_r = a[MSB];
  - set counter to WIDTH-1; partial remainder = 0; busy=1.
- IDLE -> FIX, on an edge where start=1 and b==0: set the dbz path; busy=1.
- CALC, one step per cycle:
  - shift the partial remainder left, bringing in the next dividend bit (MSB first);
  - trial-subtract |b|; if the result is non-negative, keep it and set the quotient bit to 1, else restore and set the bit to 0;
  - when counter==0, go to FIX; otherwise decrement the counter.
- FIX (one cycle):
  - quot = sign_q ? -q_mag : q_mag;
  - rem = sign_r ? -r_mag : r_mag;
  - done=1 for this one edge, busy=0, return to IDLE.
- Semantics: quotient truncates toward zero; remainder takes the sign of the dividend; a == quot*b + rem always holds, except in the overflow case.
- Latency:
  - normal: done is high in the cycle after the (WIDTH+1)th rising edge following the start-accept edge (9 edges for WIDTH=8);
  - divide by zero: done is high after 1 edge.
- Divide by zero: quot = all ones (-1), rem = a, dbz=1, ovf=0.
- Overflow (a = -2^(WIDTH-1), b = -1): ovf=1. Quotient handling depends on the optional feature; rem=0.
- start while busy: ignored, with no queuing. start asserted in the same cycle that done pulses is also ignored; it is accepted at the next IDLE edge.
- Operands a and b may change after the accept edge without effect.
- Outputs hold their last values between operations. dbz and ovf are recomputed on every completion.
- rst mid-operation: aborts immediately, no done pulse, all outputs cleared.

Optional Feature:
- Macro: DIV_OVF_SAT_EN.
- Defined: the overflow case saturates, quot = 2^(WIDTH-1)-1 (+127).
- Undefined: quot wraps to -2^(WIDTH-1) (-128).
- ovf=1 and rem=0 in both builds.

Decomposition:
- Shared package/header holds:
  - FSM state encoding (IDLE=2'd0, CALC=2'd1, FIX=2'd2);
  - the default WIDTH constant;
  - a sign-magnitude conversion function, reused by the multiplier.
- One natural sub-module: div_restore_step, a combinational single iteration.
  - Inputs: partial remainder, incoming dividend bit, |b|.
  - Outputs: next remainder, quotient bit.

Test Plan:
- Sign combinations, checking quot/rem after 9 edges with done high exactly one cycle:
  - a=100, b=7 -> quot=14, rem=2;
  - a=-100, b=7 -> quot=-14, rem=-2;
  - a=100, b=-7 -> quot=-14, rem=2;
  - a=-100, b=-7 -> quot=14, rem=-2.
- a=5, b=0 -> done after 1 edge, dbz=1, quot=-1, rem=5, ovf=0.
- a=-128, b=-1 -> ovf=1, rem=0; quot=127 with DIV_OVF_SAT_EN, quot=-128 without.
- Small-dividend cases: a=3, b=10 -> quot=0, rem=3; a=-128, b=1 -> quot=-128, rem=0.
- Start a=100, b=7, then pulse start with a=50, b=5 on cycle 3 -> the second request is ignored; the result is 14/2, and busy stays high throughout.
- Start, assert rst on cycle 4 -> all outputs 0 immediately, no done pulse. The next start a=9, b=3 -> quot=3, rem=0.
